// File: rtl/scara_stepper_pkg.sv
// scara_stepper_pkg: shared state encoding, default timing and widths for the stepper driver
package scara_stepper_pkg;
    typedef enum logic [2:0] {BOOT, DONE, IDLE, SETUP, HIGH, LOW} stepper_state_t;
    localparam int DEF_DIR_SETUP_CYCLES   = 50;
    localparam int DEF_PULSE_HIGH_CYCLES  = 100;
    localparam int DEF_STEP_PERIOD_CYCLES = 50000;
    localparam int POS_WIDTH  = 16;
    localparam int STEP_WIDTH = 8;
endpackage

// File: rtl/stepper_pulse_driver_if.sv
// stepper_pulse_driver_if: step-command bus between the SCARA controller and the pulse driver
interface stepper_pulse_driver_if;
    import scara_stepper_pkg::*;
    logic [STEP_WIDTH-1:0] steps1, steps2;
    logic dir1, dir2, dataReady, stepperReady;
    modport master(output steps1, steps2, dir1, dir2, dataReady, input stepperReady);
    modport slave(input steps1, steps2, dir1, dir2, dataReady, output stepperReady);
endinterface

// File: rtl/step_channel.sv
// step_channel: per-axis remaining count, direction latch, signed position and step pin
module step_channel
    import scara_stepper_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [STEP_WIDTH-1:0] steps,
    input  logic                  dir,
    input  logic                  stepStrobe,
    input  logic                  pulseEnd,
    output logic                  stepPin,
    output logic                  dirPin,
    output logic [POS_WIDTH-1:0]  pos,
    output logic                  remZero
);
    logic [STEP_WIDTH-1:0] rem;

    assign remZero = rem == '0;

    // A strobe on an exhausted axis is ignored, so the shorter axis simply stays low.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rem     <= '0;
            dirPin  <= 1'b0;
            pos     <= '0;
            stepPin <= 1'b0;
        end else if (load) begin
            rem    <= steps;
            dirPin <= dir;
        end else if (stepStrobe && !remZero) begin
            rem     <= rem - STEP_WIDTH'(1);
            pos     <= dirPin ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
            stepPin <= 1'b1;
        end else if (pulseEnd)
            stepPin <= 1'b0;
endmodule

// File: rtl/stepper_pulse_driver.sv
// stepper_pulse_driver: accepts two-axis step commands and emits lockstep step/dir pulses
module stepper_pulse_driver
    import scara_stepper_pkg::*;
#(
    parameter int DIR_SETUP_CYCLES   = DEF_DIR_SETUP_CYCLES,
    parameter int PULSE_HIGH_CYCLES  = DEF_PULSE_HIGH_CYCLES,
    parameter int STEP_PERIOD_CYCLES = DEF_STEP_PERIOD_CYCLES
)(
    input  logic                  clk,
    input  logic                  reset,
    stepper_pulse_driver_if.slave cmd,
    output logic                  stepPin1,
    output logic                  stepPin2,
    output logic                  dirPin1,
    output logic                  dirPin2,
    output logic                  busy,
    output logic [POS_WIDTH-1:0]  pos1,
    output logic [POS_WIDTH-1:0]  pos2
);
    localparam int LOW_CYCLES = STEP_PERIOD_CYCLES - PULSE_HIGH_CYCLES;
    localparam int MAX_CYCLES = DIR_SETUP_CYCLES > STEP_PERIOD_CYCLES ? DIR_SETUP_CYCLES : STEP_PERIOD_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    stepper_state_t state, state_nx;
    logic [CW-1:0]  cnt;
    logic           dr_q, accept, phase_end, strobe, pulse_end, rz1, rz2;

    // Edges outside IDLE are swallowed because dr_q keeps tracking the strobe level.
    assign accept = state == IDLE && cmd.dataReady && !dr_q;
    assign cmd.stepperReady = state == DONE;
    assign busy = state inside {SETUP, HIGH, LOW};

    always_comb begin
        phase_end = cnt == (state == SETUP ? CW'(DIR_SETUP_CYCLES - 1)
                          : state == HIGH  ? CW'(PULSE_HIGH_CYCLES - 1)
                          :                  CW'(LOW_CYCLES - 1));
        strobe    = phase_end && (state == SETUP || (state == LOW && !(rz1 && rz2)));
        pulse_end = phase_end && state == HIGH;
        state_nx  = state == BOOT ? DONE
                  : state == DONE ? IDLE
                  : state == IDLE ? (!accept ? IDLE : (cmd.steps1 == '0 && cmd.steps2 == '0) ? DONE : SETUP)
                  : !phase_end    ? state
                  : state == SETUP ? HIGH
                  : state == HIGH  ? LOW
                  : (rz1 && rz2)   ? DONE : HIGH;
    end

    // The phase counter restarts on every state change, so each phase times itself from zero.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= BOOT;
            cnt   <= '0;
            dr_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? '0 : cnt + CW'(1);
            dr_q  <= cmd.dataReady;
        end

    step_channel u_ch1 (
        .clk(clk), .reset(reset), .load(accept), .steps(cmd.steps1), .dir(cmd.dir1),
        .stepStrobe(strobe), .pulseEnd(pulse_end), .stepPin(stepPin1), .dirPin(dirPin1),
        .pos(pos1), .remZero(rz1)
    );

    step_channel u_ch2 (
        .clk(clk), .reset(reset), .load(accept), .steps(cmd.steps2), .dir(cmd.dir2),
        .stepStrobe(strobe), .pulseEnd(pulse_end), .stepPin(stepPin2), .dirPin(dirPin2),
        .pos(pos2), .remZero(rz2)
    );
endmodule

// File: tb/tb_stepper_pulse_driver.sv
// tb_stepper_pulse_driver: directed scoreboard bench for step timing, positions and strobe handling
module tb_stepper_pulse_driver;
    import scara_stepper_pkg::*;
    localparam int DS = 2, PH = 2, SP = 5;

    typedef struct {
        int          t;
        logic [15:0] p1, p2;
        int          n1, n2;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic stepPin1, stepPin2, dirPin1, dirPin2, busy;
    logic [15:0] pos1, pos2;
    logic wstep1, wstep2, wdir1, wdir2, wbusy;
    logic [15:0] wpos1, wpos2;
    int cyc = 0, compared = 0, mismatched = 0;
    int n1 = 0, n2 = 0;
    logic sp1_q = 1'b0, sp2_q = 1'b0;
    logic [15:0] m_p1 = '0, m_p2 = '0;
    exp_t exp_q[$];
    int rise1_q[$], rise2_q[$];

    stepper_pulse_driver_if cmd();
    stepper_pulse_driver_if wcmd();

    stepper_pulse_driver #(.DIR_SETUP_CYCLES(DS), .PULSE_HIGH_CYCLES(PH), .STEP_PERIOD_CYCLES(SP)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .stepPin1(stepPin1), .stepPin2(stepPin2),
        .dirPin1(dirPin1), .dirPin2(dirPin2), .busy(busy), .pos1(pos1), .pos2(pos2)
    );

    // Fast-timing instance so the position wrap is reachable in a modest cycle count.
    stepper_pulse_driver #(.DIR_SETUP_CYCLES(1), .PULSE_HIGH_CYCLES(1), .STEP_PERIOD_CYCLES(2)) wdut (
        .clk(clk), .reset(reset), .cmd(wcmd), .stepPin1(wstep1), .stepPin2(wstep2),
        .dirPin1(wdir1), .dirPin2(wdir2), .busy(wbusy), .pos1(wpos1), .pos2(wpos2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int e;
        exp_t x;
        if (reset) begin
            exp_q.delete();
            rise1_q.delete();
            rise2_q.delete();
            n1 = 0;
            n2 = 0;
        end else begin
            if (stepPin1 && !sp1_q) begin
                e = -1;
                if (rise1_q.size() > 0) e = rise1_q.pop_front();
                check("step1 rise cycle", cyc, e);
                n1++;
            end
            if (stepPin2 && !sp2_q) begin
                e = -1;
                if (rise2_q.size() > 0) e = rise2_q.pop_front();
                check("step2 rise cycle", cyc, e);
                n2++;
            end
            if (cmd.stepperReady) begin
                if (exp_q.size() == 0)
                    check("unexpected ready cycle", cyc, -1);
                else begin
                    x = exp_q.pop_front();
                    check("ready cycle", cyc, x.t);
                    check("pos1 at ready", {16'd0, pos1}, {16'd0, x.p1});
                    check("pos2 at ready", {16'd0, pos2}, {16'd0, x.p2});
                    check("pulses1", n1, x.n1);
                    check("pulses2", n2, x.n2);
                end
                n1 = 0;
                n2 = 0;
            end
        end
        sp1_q = stepPin1;
        sp2_q = stepPin2;
    end

    task automatic push_boot();
        exp_t x;
        x.t = cyc + 1;
        x.p1 = '0;
        x.p2 = '0;
        x.n1 = 0;
        x.n2 = 0;
        exp_q.push_back(x);
    endtask

    // Called at a negedge; the following posedge is the accept edge.
    task automatic send(input logic [7:0] s1, input logic d1, input logic [7:0] s2, input logic d2, input bit hold);
        exp_t x;
        int a, n;
        cmd.steps1 = s1;
        cmd.dir1 = d1;
        cmd.steps2 = s2;
        cmd.dir2 = d2;
        cmd.dataReady = 1'b1;
        a = cyc + 1;
        n = s1 > s2 ? int'(s1) : int'(s2);
        for (int k = 0; k < int'(s1); k++) rise1_q.push_back(a + DS + k * SP);
        for (int k = 0; k < int'(s2); k++) rise2_q.push_back(a + DS + k * SP);
        m_p1 = d1 ? m_p1 + 16'(s1) : m_p1 - 16'(s1);
        m_p2 = d2 ? m_p2 + 16'(s2) : m_p2 - 16'(s2);
        x.t = n == 0 ? a : a + DS + n * SP;
        x.p1 = m_p1;
        x.p2 = m_p2;
        x.n1 = int'(s1);
        x.n2 = int'(s2);
        exp_q.push_back(x);
        @(negedge clk);
        if (!hold) cmd.dataReady = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int i = 0;
        while (!cmd.stepperReady && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'd0, cmd.stepperReady}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wmove(input logic [7:0] s, input logic d);
        int i = 0;
        wcmd.steps1 = s;
        wcmd.dir1 = d;
        wcmd.dataReady = 1'b1;
        @(negedge clk);
        wcmd.dataReady = 1'b0;
        while (!wcmd.stepperReady && i < 600) begin
            @(negedge clk);
            i++;
        end
        check("wrap move done", {31'd0, wcmd.stepperReady}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int i;
        cmd.steps1 = '0; cmd.steps2 = '0; cmd.dir1 = 1'b0; cmd.dir2 = 1'b0; cmd.dataReady = 1'b0;
        wcmd.steps1 = '0; wcmd.steps2 = '0; wcmd.dir1 = 1'b0; wcmd.dir2 = 1'b0; wcmd.dataReady = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {stepPin1, stepPin2, dirPin1, dirPin2, busy, cmd.stepperReady, pos1, pos2}, 38'd0);
        reset = 1'b0;
        push_boot();
        @(negedge clk);
        check("boot ready pulse", {30'd0, cmd.stepperReady, busy}, 32'd2);
        @(negedge clk);
        check("boot ready drop", {31'd0, cmd.stepperReady}, 32'd0);

        send(8'd3, 1'b1, 8'd1, 1'b0, 1'b0);
        check("dir latch move1", {30'd0, dirPin1, dirPin2}, 32'd2);
        check("busy move1", {31'd0, busy}, 32'd1);
        wait_ready(40, "move1 ready");
        check("pos1 after move1", {16'd0, pos1}, 32'h0003);
        check("pos2 after move1", {16'd0, pos2}, 32'hFFFF);

        send(8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        wait_ready(5, "zero cmd ready");
        check("dir latch zero cmd", {30'd0, dirPin1, dirPin2}, 32'd1);

        send(8'd2, 1'b0, 8'd2, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        cmd.steps1 = 8'd9;
        cmd.dir1 = 1'b1;
        cmd.dataReady = 1'b1;
        @(negedge clk);
        cmd.dataReady = 1'b0;
        check("dir kept on ignored strobe", {31'd0, dirPin1}, 32'd0);
        wait_ready(40, "ignored strobe ready");

        send(8'd1, 1'b1, 8'd0, 1'b0, 1'b1);
        wait_ready(20, "held strobe ready");
        for (int k = 0; k < 6; k++) begin
            check("held strobe no retrigger", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        cmd.dataReady = 1'b0;
        @(negedge clk);

        send(8'd4, 1'b1, 8'd4, 1'b0, 1'b0);
        i = 0;
        while (!stepPin1 && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("mid-move step seen", {31'd0, stepPin1}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async reset mid-move", {15'd0, stepPin1, stepPin2, busy, pos1}, {18'd0, 16'd0});
        check("async reset pos2", {16'd0, pos2}, 32'd0);
        m_p1 = '0;
        m_p2 = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_boot();
        wait_ready(5, "reboot ready");

        send(8'd2, 1'b0, 8'd5, 1'b1, 1'b0);
        wait_ready(60, "move after reboot ready");
        check("pos1 after reboot move", {16'd0, pos1}, 32'hFFFE);
        check("pos2 after reboot move", {16'd0, pos2}, 32'h0005);
        check("scoreboard drained", exp_q.size(), 0);
        check("rise queues drained", rise1_q.size() + rise2_q.size(), 0);

        for (int k = 0; k < 129; k++) wmove(k < 128 ? 8'd255 : 8'd127, 1'b1);
        check("wrap pos at 7fff", {16'd0, wpos1}, 32'h7FFF);
        wmove(8'd1, 1'b1);
        check("wrap pos to 8000", {16'd0, wpos1}, 32'h8000);
        wmove(8'd255, 1'b0);
        check("wrap pos back to 7f01", {16'd0, wpos1}, 32'h7F01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
